ex_div: RTL

Iterative 32-bit integer divider for the execute stage. Consumes RISC-V M-extension DIV/DIVU/REM/REMU operands that the ID/EX pipeline register delivers to ex, runs a radix-2 restoring division over 32 cycles, and returns quotient or remainder plus the destination register address. While it works it holds `busy` high, and ex converts that into a pipeline hold so that ID/EX and earlier stages stall.

---
 rtl/ex_div.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One quotient bit per cycle over 32 CALC cycles; divide-by-zero and signed
// overflow bypass CALC and complete through END on the next edge.
module ex_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [4:0]       reg_waddr_i,
  input  logic             abort,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       reg_waddr_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StEnd} state_e;

  state_e           state_q, state_d;
  logic [4:0]       count_q;
  logic [WIDTH-1:0] quo_q, rem_q, dsor_q;
  logic [4:0]       waddr_q;
  logic             is_rem_q, special_q, neg_quo_q, neg_rem_q;

  // Request decode, evaluated on the operands presented in IDLE.
  logic             is_signed, div_zero, overflow;
  logic [WIDTH-1:0] abs_a, abs_b;
  // One restoring step: shift in the next dividend bit, trial-subtract.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] sub;
  logic             borrow;
  // Sign-corrected outcome published from END.
  logic [WIDTH-1:0] quo_fix, rem_fix, end_res;
  // op[2] is always set for the divide group and carries no information;
  // sub[WIDTH] is provably zero whenever the difference is kept.
  logic             unused_bits;

  assign is_signed = ~op[0];
  assign div_zero  = (divisor == '0);
  assign overflow  = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
  assign abs_a     = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_b     = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
  assign sub       = {1'b0, rem_sh} - {2'b00, dsor_q};
  assign borrow    = sub[WIDTH+1];

  assign quo_fix   = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix   = neg_rem_q ? -rem_q : rem_q;
  assign end_res   = special_q ? quo_q : (is_rem_q ? rem_fix : quo_fix);

  assign unused_bits = op[2] ^ sub[WIDTH];

  assign busy = (state_q != StIdle);

  // Next-state logic; abort overrides everything, including END.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = (div_zero || overflow) ? StEnd : StCalc;
      StCalc: if (count_q == 5'd31) state_d = StEnd;
      StEnd:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dsor_q      <= '0;
      waddr_q     <= '0;
      is_rem_q    <= 1'b0;
      special_q   <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      ready       <= 1'b0;
      result      <= '0;
      reg_waddr_o <= '0;
    end else begin
      ready <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start && !abort) begin
            is_rem_q  <= op[1];
            waddr_q   <= reg_waddr_i;
            count_q   <= '0;
            special_q <= div_zero || overflow;
            neg_quo_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_q <= is_signed && dividend[WIDTH-1];
            dsor_q    <= abs_b;
            rem_q     <= '0;
            // Special results are parked in quo_q and bypass sign correction.
            if (div_zero)      quo_q <= op[1] ? dividend : '1;
            else if (overflow) quo_q <= op[1] ? '0 : dividend;
            else               quo_q <= abs_a;
          end
        end
        StCalc: begin
          count_q <= count_q + 5'd1;
          if (!borrow) begin
            rem_q <= sub[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= rem_sh[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
        end
        StEnd: begin
          if (!abort) begin
            result      <= end_res;
            reg_waddr_o <= waddr_q;
            ready       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
